// File: rtl/drex7_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : drex7_sprite_fetch
//  Description : Sprite hit test and ROM address generation for the drex7
//                sprite. Returns a palette index and an opaque flag two pixel
//                clocks after the draw coordinates. The sprite position and
//                mirror are latched once per frame, and the animation frame
//                is stepped on a frame divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module drex7_sprite_fetch #(
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 32,
    parameter int FRAMES    = 4,
    parameter int FRAME_DIV = 8,
    parameter int KEY_INDEX = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   frame_start,
    input  logic [9:0]                             pos_x,
    input  logic [9:0]                             pos_y,
    input  logic                                   mirror_req,
    input  logic                                   anim_en,
    input  logic [9:0]                             draw_x,
    input  logic [9:0]                             draw_y,
    input  logic                                   de,
    output logic [$clog2(FRAMES*SPR_W*SPR_H)-1:0]  rom_addr,
    input  logic [3:0]                             rom_data,
    output logic [3:0]                             pix_index,
    output logic                                   pix_opaque,
    output logic [$clog2(FRAMES)-1:0]              cur_frame
);

    localparam int c_ADDR_W  = $clog2(FRAMES*SPR_W*SPR_H);
    localparam int c_COL_W   = $clog2(SPR_W);
    localparam int c_ROW_W   = $clog2(SPR_H);
    localparam int c_FRAME_W = $clog2(FRAMES);
    localparam int c_DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [10:0]          c_SPR_W_EXT = 11'(SPR_W);
    localparam logic [10:0]          c_SPR_H_EXT = 11'(SPR_H);
    localparam logic [c_COL_W-1:0]   c_COL_MAX   = c_COL_W'(SPR_W - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST  = c_DIV_W'(FRAME_DIV - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_ONE = c_FRAME_W'(1);
    localparam logic [3:0]           c_KEY       = 4'(KEY_INDEX);

    // Shadow copies of the requested position, only updated at frame_start
    logic [9:0]           r_lx;
    logic [9:0]           r_ly;
    logic                 r_mirror;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_FRAME_W-1:0] r_frame;

    // Pipeline registers
    logic                 r_hit1;
    logic [c_ADDR_W-1:0]  r_rom_addr;
    logic [3:0]           r_pix_index;
    logic                 r_pix_opaque;

    // Stage 0 combinational hit test. Subtraction is done at 11 bits so a
    // pixel left of / above the sprite shows up as a set sign bit rather
    // than wrapping to a large positive offset.
    logic [10:0]          w_dx;
    logic [10:0]          w_dy;
    logic                 w_hit;
    logic [c_COL_W-1:0]   w_col;

    assign w_dx  = {1'b0, draw_x} - {1'b0, r_lx};
    assign w_dy  = {1'b0, draw_y} - {1'b0, r_ly};
    assign w_hit = de
                 & ~w_dx[10] & (w_dx < c_SPR_W_EXT)
                 & ~w_dy[10] & (w_dy < c_SPR_H_EXT);
    assign w_col = r_mirror ? (c_COL_MAX - w_dx[c_COL_W-1:0]) : w_dx[c_COL_W-1:0];

    // Per-frame position latch and animation divider; the current pixel
    // lookup still sees the old values on a coincident frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lx     <= '0;
            r_ly     <= '0;
            r_mirror <= 1'b0;
            r_div    <= '0;
            r_frame  <= '0;
        end else if (frame_start) begin
            r_lx     <= pos_x;
            r_ly     <= pos_y;
            r_mirror <= mirror_req;
            if (anim_en) begin
                if (r_div == c_DIV_LAST) begin
                    r_div   <= '0;
                    r_frame <= r_frame + c_FRAME_ONE;
                end else begin
                    r_div   <= r_div + c_DIV_ONE;
                end
            end
        end
    end

    // Stage 1: present the ROM address for hitting pixels; hold it otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit1     <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_hit1 <= w_hit;
            if (w_hit) begin
                r_rom_addr <= {r_frame, w_dy[c_ROW_W-1:0], w_col};
            end
        end
    end

    // Stage 2: qualify ROM data with the delayed hit and flag transparency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_index  <= '0;
            r_pix_opaque <= 1'b0;
        end else begin
            r_pix_index  <= r_hit1 ? rom_data : c_KEY;
            r_pix_opaque <= r_hit1 & (rom_data != c_KEY);
        end
    end

    assign rom_addr   = r_rom_addr;
    assign pix_index  = r_pix_index;
    assign pix_opaque = r_pix_opaque;
    assign cur_frame  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_drex7_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drex7_sprite_fetch
//  Description : Directed self-checking bench for drex7_sprite_fetch. The
//                sprite ROM array is read from the DUT's registered rom_addr,
//                so rom_data belongs to the address issued one cycle earlier.
//                ROM content: key_mode ? 0 : addr[3:0] + 5 (mod 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drex7_sprite_fetch;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        mirror_req;
    logic        anim_en;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        de;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pix_index;
    logic        pix_opaque;
    logic [1:0]  cur_frame;
    logic        key_mode;

    int n_tests;
    int n_fail;

    drex7_sprite_fetch #(
        .SPR_W     (32),
        .SPR_H     (32),
        .FRAMES    (4),
        .FRAME_DIV (8),
        .KEY_INDEX (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .mirror_req  (mirror_req),
        .anim_en     (anim_en),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .de          (de),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_index   (pix_index),
        .pix_opaque  (pix_opaque),
        .cur_frame   (cur_frame)
    );

    // Pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM array behind the DUT's address register
    assign rom_data = key_mode ? 4'd0 : (rom_addr[3:0] + 4'd5);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One pixel lookup followed by idle: address checked after one clock
    // (only when a hit is expected), index/opaque after two.
    task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic den, input logic exp_hit, input logic [11:0] exp_addr,
                      input logic [3:0] exp_idx, input logic exp_opq);
        draw_x = x;
        draw_y = y;
        de     = den;
        tick();
        if (exp_hit) chk({tag, " rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        de = 1'b0;
        tick();
        chk({tag, " pix_index"},  32'(pix_index),  32'(exp_idx));
        chk({tag, " pix_opaque"}, 32'(pix_opaque), 32'(exp_opq));
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        frame_start = 1'b0;
        pos_x       = 10'd0;
        pos_y       = 10'd0;
        mirror_req  = 1'b0;
        anim_en     = 1'b0;
        draw_x      = 10'd0;
        draw_y      = 10'd0;
        de          = 1'b0;
        key_mode    = 1'b0;
        tick();
        tick();
        chk("reset rom_addr",   32'(rom_addr),   32'd0);
        chk("reset pix_index",  32'(pix_index),  32'd0);
        chk("reset pix_opaque", 32'(pix_opaque), 32'd0);
        chk("reset cur_frame",  32'(cur_frame),  32'd0);
        reset = 1'b0;
        tick();

        // Position (100,50), no mirror
        pos_x = 10'd100; pos_y = 10'd50; mirror_req = 1'b0;
        frame_pulse();
        px("tl",        10'd100, 10'd50, 1'b1, 1'b1, 12'd0,    4'd5, 1'b1);
        px("left out",  10'd99,  10'd50, 1'b1, 1'b0, 12'd0,    4'd0, 1'b0);
        px("right out", 10'd132, 10'd50, 1'b1, 1'b0, 12'd0,    4'd0, 1'b0);
        px("br",        10'd131, 10'd81, 1'b1, 1'b1, 12'd1023, 4'd4, 1'b1);
        px("below out", 10'd100, 10'd82, 1'b1, 1'b0, 12'd0,    4'd0, 1'b0);
        px("de low",    10'd100, 10'd50, 1'b0, 1'b0, 12'd0,    4'd0, 1'b0);

        // Mirrored
        mirror_req = 1'b1;
        frame_pulse();
        px("mir tl", 10'd100, 10'd50, 1'b1, 1'b1, 12'd31,  4'd4, 1'b1);
        px("mir br", 10'd131, 10'd81, 1'b1, 1'b1, 12'd992, 4'd5, 1'b1);

        // Transparent ROM content inside the sprite
        key_mode = 1'b1;
        px("key", 10'd100, 10'd50, 1'b1, 1'b1, 12'd31, 4'd0, 1'b0);
        key_mode = 1'b0;

        // Animation: 8 pulses per step
        mirror_req = 1'b0;
        anim_en    = 1'b1;
        for (int i = 0; i < 7; i++) frame_pulse();
        chk("anim 7 pulses", 32'(cur_frame), 32'd0);
        frame_pulse();
        chk("anim 8 pulses", 32'(cur_frame), 32'd1);
        for (int i = 0; i < 8; i++) frame_pulse();
        chk("anim 16 pulses", 32'(cur_frame), 32'd2);
        px("frame2", 10'd100, 10'd50, 1'b1, 1'b1, 12'd2048, 4'd5, 1'b1);
        for (int i = 0; i < 16; i++) frame_pulse();
        chk("anim wrap 32", 32'(cur_frame), 32'd0);
        anim_en = 1'b0;
        for (int i = 0; i < 9; i++) frame_pulse();
        chk("anim hold", 32'(cur_frame), 32'd0);
        anim_en = 1'b1;
        for (int i = 0; i < 8; i++) frame_pulse();
        chk("anim resume", 32'(cur_frame), 32'd1);
        anim_en = 1'b0;

        // Reset mid-sprite while opaque
        draw_x = 10'd100; draw_y = 10'd50; de = 1'b1;
        tick();
        chk("pre-reset rom_addr", 32'(rom_addr), 32'd1024);
        tick();
        chk("pre-reset opaque", 32'(pix_opaque), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid reset pix_index",  32'(pix_index),  32'd0);
        chk("mid reset pix_opaque", 32'(pix_opaque), 32'd0);
        chk("mid reset cur_frame",  32'(cur_frame),  32'd0);
        chk("mid reset rom_addr",   32'(rom_addr),   32'd0);
        reset = 1'b0;
        de    = 1'b0;
        // Latch cleared to (0,0): (100,50) misses, (0,0) hits
        px("post-reset miss", 10'd100, 10'd50, 1'b1, 1'b0, 12'd0, 4'd0, 1'b0);
        px("post-reset hit",  10'd0,   10'd0,  1'b1, 1'b1, 12'd0, 4'd5, 1'b1);

        // Position changes only take effect at frame_start
        pos_x = 10'd100; pos_y = 10'd50; mirror_req = 1'b0;
        frame_pulse();
        pos_x = 10'd200;
        px("no latch old", 10'd100, 10'd50, 1'b1, 1'b1, 12'd0, 4'd5, 1'b1);
        px("no latch new", 10'd200, 10'd50, 1'b1, 1'b0, 12'd0, 4'd0, 1'b0);
        // frame_start coincident with a hitting pixel uses the old position
        draw_x = 10'd100; draw_y = 10'd51; de = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        de          = 1'b0;
        chk("coinc rom_addr", 32'(rom_addr), 32'd32);
        tick();
        chk("coinc pix_opaque", 32'(pix_opaque), 32'd1);
        chk("coinc pix_index",  32'(pix_index),  32'd5);
        px("latched old miss", 10'd100, 10'd50, 1'b1, 1'b0, 12'd0,  4'd0, 1'b0);
        px("latched new hit",  10'd203, 10'd50, 1'b1, 1'b1, 12'd3,  4'd8, 1'b1);

        // Right-edge clip with no wrap to column 0
        pos_x = 10'd1000;
        frame_pulse();
        px("edge hit",  10'd1010, 10'd50, 1'b1, 1'b1, 12'd10, 4'd15, 1'b1);
        px("edge wrap", 10'd4,    10'd50, 1'b1, 1'b0, 12'd0,  4'd0,  1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drex7_sprite_fetch.md
Name: drex7_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of drex7_palette.
- For each VGA pixel it decides whether the pixel falls inside the drex7 sprite and drives the sprite ROM address. It then returns the 4-bit palette index plus an opaque flag, aligned to the pixel stream with fixed latency.
- It also latches the sprite position once per frame, so the sprite cannot tear mid-frame, and steps the animation frame counter.

Parameters:
SPR_W, 32, sprite width in pixels (power of 2)
SPR_H, 32, sprite height in pixels (power of 2)
FRAMES, 4, animation frames stored back-to-back in ROM (power of 2)
FRAME_DIV, 8, video frames per animation step (>=1)
KEY_INDEX, 0, palette index treated as transparent (entry 0 = white key)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pos_x  in  10  requested sprite left edge (screen pixels)
pos_y  in  10  requested sprite top edge
mirror_req  in  1  requested horizontal mirror (tank facing left)
anim_en  in  1  1 = advance animation, 0 = hold current frame
draw_x  in  10  current pixel column
draw_y  in  10  current pixel row
de  in  1  display enable, 1 = active video
rom_addr  out  log2(FRAMES*SPR_W*SPR_H)  sprite ROM address; the ROM is synchronous with 1-cycle read latency
rom_data  in  4  ROM data for the address presented on the previous cycle
pix_index  out  4  palette index to drex7_palette
pix_opaque  out  1  1 = sprite pixel present and not KEY_INDEX
cur_frame  out  log2(FRAMES)  current animation frame

Behaviour:
- Reset (synchronous, active-high, priority over all other inputs) clears every register:
  - rom_addr=0, pix_index=0, pix_opaque=0, cur_frame=0.
  - Latched pos_x/pos_y/mirror = 0, FRAME_DIV counter=0, pipeline valid bits=0.
- Position latch:
  - pos_x, pos_y and mirror_req are sampled into shadow registers only on a cycle with frame_start=1.
  - Changes at any other time have no effect until the next frame_start.
- Animation:
  - On frame_start with anim_en=1, the divider increments.
  - When the divider reaches FRAME_DIV-1 it returns to 0 and cur_frame increments, wrapping from FRAMES-1 to 0.
  - With anim_en=0 the divider and cur_frame hold.
  - FRAME_DIV=1 steps cur_frame every frame_start.
- Stage 0 (combinational on draw_x/draw_y):
  - Define dx=draw_x-lx and dy=draw_y-ly, with arithmetic done at 11 bits so an underflow sets the sign bit.
  - hit = de & draw_x>=lx & dx<SPR_W & draw_y>=ly & dy<SPR_H.
  - Sprites partially off the right or bottom screen edge simply never hit the off-screen part. There is no wrap to column 0.
  - col = mirror ? SPR_W-1-dx : dx.
- Cycle 1 (registered):
  - rom_addr <= {cur_frame, dy[row bits], col}, i.e. frame*SPR_W*SPR_H + dy*SPR_W + col.
  - hit1 <= hit.
  - When hit=0, rom_addr holds its previous value; it is a don't-care.
- Cycle 2 (registered):
  - pix_index <= hit1 ? rom_data : KEY_INDEX.
  - pix_opaque <= hit1 & (rom_data != KEY_INDEX).
- Total latency: 2 clk cycles from draw_x/draw_y to pix_index/pix_opaque, constant, including at line and frame boundaries. The downstream compositor delays draw coordinates accordingly.
- Simultaneous events: a frame_start in the same cycle as a pixel lookup updates the shadow registers and cur_frame at the clock edge. That lookup uses the old values; the next pixel uses the new ones.
- Reset mid-line: outputs go to their reset values on the next edge. The first valid pix_opaque after reset release comes 2 cycles after the first hitting pixel.
- de=0 forces hit=0, so pix_opaque=0 two cycles later.

Test Plan:
- Reset asserted while mid-sprite with pix_opaque=1 -> the next cycle shows pix_index=0, pix_opaque=0, cur_frame=0.
- frame_start with pos=(100,50), mirror=0; draw (100,50) with ROM address 0 holding 5 -> rom_addr=0 one cycle later, pix_index=5 and pix_opaque=1 two cycles later. Draw (99,50) and (132,50) -> pix_opaque=0.
- Same position with mirror=1; draw (100,50) -> rom_addr=31. Draw (131,81) -> rom_addr=992.
- ROM returns 0 (KEY_INDEX) inside the sprite -> pix_index=0, pix_opaque=0.
- anim_en=1, FRAME_DIV=8: 8 frame_start pulses -> cur_frame 0->1. 32 pulses -> wraps back to 0. At cur_frame=2, draw (100,50) -> rom_addr=2048.
- pos_x changed to 200 mid-frame, no frame_start -> still hits at x=100. After the next frame_start -> hits at x=200 only. frame_start coincident with a hitting pixel -> that pixel still uses the old position.
